// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider controller.
package div_pkg;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported by the local divide-by-zero fast path.
  localparam logic [DATA_W-1:0] DZ_QUOTIENT = {DATA_W{1'b1}};
endpackage

// File: rtl/div_ctrl.sv
// Initiator-side controller for the iterative divider in EX.
// Optional feature: define DIV_BYZERO_FAST_EN to complete divide-by-zero
// locally (quotient all ones, remainder = dividend) without starting the divider.
module div_ctrl
  import div_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_i,
  input  logic         signed_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  input  logic         flush_i,
  output logic         stall_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic         dz_o,
  output logic         div_start_o,
  output logic         div_annul_o,
  output logic         div_signed_o,
  output logic [W-1:0] div_opdata1_o,
  output logic [W-1:0] div_opdata2_o,
  input  logic         div_ready_i,
  input  logic [W-1:0] div_quotient_i,
  input  logic [W-1:0] div_remainder_i
);

  div_state_e state, state_nx;
  logic       accept;
  logic       div_zero;

  assign accept   = (state == IDLE) && req_i && !flush_i;
  assign div_zero = (divisor_i == '0);

  // State register plus operand/result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      dz_o          <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        div_signed_o  <= signed_i;
        div_opdata1_o <= dividend_i;
        div_opdata2_o <= divisor_i;
        dz_o          <= div_zero;
`ifdef DIV_BYZERO_FAST_EN
        if (div_zero) begin
          quotient_o  <= DZ_QUOTIENT;
          remainder_o <= dividend_i;
        end
`endif
      end
      // Flush beats a same-cycle ready: no capture.
      if (state == BUSY && div_ready_i && !flush_i) begin
        quotient_o  <= div_quotient_i;
        remainder_o <= div_remainder_i;
      end
    end
  end

  // Next state and divider/pipeline handshake outputs.
  always_comb begin
    state_nx    = state;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          // Reset is async; keep the stall low while it is asserted.
          stall_o = !rst;
`ifdef DIV_BYZERO_FAST_EN
          state_nx = div_zero ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_nx    = IDLE;
        end else begin
          div_start_o = 1'b1;
          if (div_ready_i) state_nx = DONE;
        end
      end
      DONE: begin
        done_o   = !flush_i;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Initiator-side controller for the iterative divider in the execute stage. Accepts a divide request from the pipeline and drives the divider's start/annul/operand inputs. Stalls the pipeline until the divider signals ready, then captures the quotient and remainder and presents them for one cycle. Also handles pipeline flushes, divide-by-zero flagging and an optional local divide-by-zero fast path.

## Interface
- DATA_W, 24, operand/result width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_i  in  1  divide instruction valid in EX; held while stall_o=1
- signed_i  in  1  signed divide
- dividend_i  in  DATA_W  dividend
- divisor_i  in  DATA_W  divisor
- flush_i  in  1  pipeline flush; kills the in-flight divide
- stall_o  out  1  pipeline stall request
- done_o  out  1  one-cycle pulse; results valid
- quotient_o  out  DATA_W  captured quotient
- remainder_o  out  DATA_W  captured remainder
- dz_o  out  1  captured divisor==0 flag, valid with done_o
- div_start_o  out  1  to divider start_i
- div_annul_o  out  1  to divider annul_i
- div_signed_o  out  1  to divider signed_div_i
- div_opdata1_o  out  DATA_W  to divider opdata1_i
- div_opdata2_o  out  DATA_W  to divider opdata2_i
- div_ready_i  in  1  from divider ready_o
- div_quotient_i  in  DATA_W  from divider quotient_o
- div_remainder_i  in  DATA_W  from divider remainder_o

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On req_i & !flush_i: latch signed_i, dividend_i and divisor_i into the div_* operand registers; latch dz = (divisor_i==0); go to BUSY.
- BUSY:
  - div_start_o=1; operands held stable.
  - On div_ready_i: capture div_quotient_i and div_remainder_i into quotient_o/remainder_o; go to DONE (div_start_o drops).
- DONE:
  - done_o=1 and stall_o=0; always returns to IDLE next cycle.
- stall_o (combinational) = (IDLE & req_i & !flush_i) | BUSY.
- flush_i has priority in every state:
  - In BUSY: div_annul_o=1 and div_start_o=0 for one cycle, then IDLE, no done_o.
  - In IDLE: the request is not accepted.
  - In DONE: done_o is masked.
- div_ready_i outside BUSY is ignored.
- Operands are passed to the divider raw; sign handling belongs to the divider.
- quotient_o, remainder_o and dz_o hold their values until the next capture.

## Timing
- Reset: state IDLE. stall_o, done_o, dz_o, div_start_o, div_annul_o, div_signed_o = 0. quotient_o, remainder_o, div_opdata1_o, div_opdata2_o = 0.
- Cycle 0: request accepted. Cycle 1: div_start_o high.
  - If div_ready_i is first sampled high in cycle k, done_o is high in cycle k+1 and div_start_o is low from cycle k+1.
- The divider holds ready_o until start drops; the controller drops start exactly one cycle after sampling ready.
- Back-to-back divides: DONE→IDLE costs one cycle. Accept of the next request occurs in the cycle after done_o.
- Reset mid-BUSY: immediate return to IDLE with all outputs cleared; the divider shares rst.
- Flush in the same cycle as div_ready_i in BUSY: flush wins. No capture, annul pulses.

## Configuration
- DIV_BYZERO_FAST_EN defined:
  - IDLE accept with divisor_i==0 goes directly to DONE; the divider is never started.
  - quotient_o = all ones (24'hFFFFFF), remainder_o = dividend_i, dz_o=1, done_o in cycle 1.
- Undefined: divide-by-zero is forwarded to the divider like any request. dz_o=1 still; results are whatever the divider returns.

## Structure
- Shared package div_pkg:
  - DATA_W default constant.
  - FSM state typedef (IDLE/BUSY/DONE).
  - DZ_QUOTIENT constant (all ones).
- Single module, no sub-module. Instantiated beside div in the EX stage; stall_o feeds the pipeline stall controller.

## Test plan
- Unsigned 703/37: stall through BUSY; done_o one cycle after ready; quotient 19, remainder 0, dz_o=0.
- Signed 0xFFFD3F (−705) / 37: quotient 0xFFFFED (−19), remainder 0xFFFFFE (−2); div_signed_o=1 throughout BUSY.
- Flush 5 cycles into BUSY: one-cycle div_annul_o, div_start_o low, IDLE next, no done_o, quotient_o unchanged.
- Divide 100/0 with DIV_BYZERO_FAST_EN: done_o at cycle 1, quotient 0xFFFFFF, remainder 100, dz_o=1, div_start_o never high. Without the macro: the divider is started and dz_o=1 at done.
- rst asserted mid-BUSY: all outputs 0 immediately. A new 705/37 after release gives quotient 19, remainder 2.
- Back-to-back divides 703/37 then 40/6: second accept in the cycle after the first done_o; results 19/0 then 6/4.
